tank_level_encoder: RTL and testbench

//  Per-tank front end for the pump controller: synchronises and debounces four float-switch probes,

---
 rtl/tank_level_encoder_pkg.sv | 54 +++++
 rtl/tank_level_encoder_probe_debouncer.sv | 45 ++++
 rtl/tank_level_encoder.sv | 164 ++++++++++++++++
 tb/tb_tank_level_encoder.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/tank_level_encoder_pkg.sv
// Shared level-code constants, FSM states and decode helpers for the tank level encoder.
// The pump controller imports the same level-code constants.
package tank_level_encoder_pkg;

    localparam int NUM_PROBES = 4;

    localparam logic [2:0] LVL_0       = 3'd0;
    localparam logic [2:0] LVL_25      = 3'd1;
    localparam logic [2:0] LVL_50      = 3'd2;
    localparam logic [2:0] LVL_75      = 3'd3;
    localparam logic [2:0] LVL_100     = 3'd4;
    localparam logic [2:0] LVL_INVALID = 3'd7;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_VALID = 2'd1,
        ST_PEND  = 2'd2,
        ST_FAULT = 2'd3
    } lvl_state_e;

    typedef struct packed {
        logic       legal;
        logic [2:0] code;
    } lvl_decode_t;

    // Clocks per 1 ms tick.
    function automatic int unsigned tick_div(input int unsigned clk_hz);
        return clk_hz / 1000;
    endfunction

    // Only thermometer patterns filled from the 25 % probe upward are legal.
    function automatic lvl_decode_t decode_probes(input logic [NUM_PROBES-1:0] v);
        lvl_decode_t d;
        d.legal = 1'b1;
        d.code  = LVL_0;
        case (v)
            4'b0000: d.code = LVL_0;
            4'b0001: d.code = LVL_25;
            4'b0011: d.code = LVL_50;
            4'b0111: d.code = LVL_75;
            4'b1111: d.code = LVL_100;
            default: begin
                d.legal = 1'b0;
                d.code  = LVL_INVALID;
            end
        endcase
        return d;
    endfunction

    function automatic logic [2:0] code_dist(input logic [2:0] a, input logic [2:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/tank_level_encoder_probe_debouncer.sv
// One float-switch probe: 2-FF synchroniser, polarity fix-up and tick-counted debounce.
module tank_level_encoder_probe_debouncer #(
    parameter int unsigned DEBOUNCE_MS      = 5,
    parameter bit          PROBE_ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_tick,
    input  logic i_probe,
    output logic o_stable
);

    localparam int CW = $clog2(DEBOUNCE_MS + 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_stable;
    logic          w_synced;

    assign w_synced = r_sync[1] ^ PROBE_ACTIVE_LOW;
    assign o_stable = r_stable;

    // Counter only advances while the input disagrees; it is cleared on acceptance
    // before it can pass DEBOUNCE_MS-1, so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= '0;
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_probe};
            if (w_synced == r_stable) begin
                r_cnt <= '0;
            end else if (i_tick) begin
                if (r_cnt >= CW'(DEBOUNCE_MS - 1)) begin
                    r_stable <= w_synced;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/tank_level_encoder.sv
// Per-tank level encoder: debounced probes -> validated thermometer decode -> 3-bit level code.
// Optional level-jump check is compiled in with `define LVL_ENC_RATE_CHECK_EN.
module tank_level_encoder
    import tank_level_encoder_pkg::*;
#(
    parameter int unsigned CLK_HZ             = 50_000_000,
    parameter int unsigned DEBOUNCE_MS        = 5,
    parameter int unsigned INVALID_CONFIRM_MS = 3,
    parameter bit          PROBE_ACTIVE_LOW   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_PROBES-1:0] probe_in,
    output logic [2:0]            level_code,
    output logic                  level_valid,
    output logic                  code_changed,
    output logic                  pattern_err,
    output logic                  rate_err
);

    localparam int unsigned TICK_DIV = tick_div(CLK_HZ);
    localparam int DW  = $clog2(TICK_DIV + 1);
    localparam int IW  = $clog2(DEBOUNCE_MS + 1);
    localparam int CCW = $clog2(INVALID_CONFIRM_MS + 1);

    logic [DW-1:0]         r_div;
    logic                  w_tick;
    logic [NUM_PROBES-1:0] w_stable;
    logic [NUM_PROBES-1:0] r_stable_prev;
    logic                  w_pat_chg;
    lvl_decode_t           w_dec;
    logic                  w_jump;
    logic                  w_bad;

    lvl_state_e            r_state, w_state_nxt;
    logic [IW-1:0]         r_init_cnt, w_init_cnt_nxt;
    logic [CCW-1:0]        r_conf_cnt, w_conf_cnt_nxt;
    logic [2:0]            r_code, w_code_nxt;
    logic                  r_valid, w_valid_nxt;
    logic                  r_perr, w_perr_nxt;
    logic                  r_changed;

    assign w_tick = (r_div == DW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_div <= '0;
        else        r_div <= w_tick ? '0 : r_div + 1'b1;
    end

    for (genvar g = 0; g < NUM_PROBES; g++) begin : g_probe
        tank_level_encoder_probe_debouncer #(
            .DEBOUNCE_MS      (DEBOUNCE_MS),
            .PROBE_ACTIVE_LOW (PROBE_ACTIVE_LOW)
        ) u_deb (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_tick   (w_tick),
            .i_probe  (probe_in[g]),
            .o_stable (w_stable[g])
        );
    end

    assign w_dec     = decode_probes(w_stable);
    assign w_pat_chg = (w_stable != r_stable_prev);

`ifdef LVL_ENC_RATE_CHECK_EN
    logic r_rate_err;
    // Jumps are judged against the last real measurement only, so INIT/FAULT exits never trip it.
    assign w_jump = r_valid && w_dec.legal && (code_dist(w_dec.code, r_code) >= 3'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              r_rate_err <= 1'b0;
        else if (r_state == ST_VALID && w_jump)  r_rate_err <= 1'b1;
    end
    assign rate_err = r_rate_err;
`else
    assign w_jump   = 1'b0;
    assign rate_err = 1'b0;
`endif

    assign w_bad = !w_dec.legal || w_jump;

    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        w_conf_cnt_nxt = r_conf_cnt;
        w_code_nxt     = r_code;
        w_valid_nxt    = r_valid;
        w_perr_nxt     = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_code_nxt  = LVL_0;
                w_valid_nxt = 1'b0;
                if (w_tick) begin
                    if (r_init_cnt >= IW'(DEBOUNCE_MS)) begin
                        w_state_nxt    = w_dec.legal ? ST_VALID : ST_PEND;
                        w_conf_cnt_nxt = '0;
                    end else begin
                        w_init_cnt_nxt = r_init_cnt + 1'b1;
                    end
                end
            end
            ST_VALID: begin
                if (w_bad) begin
                    w_state_nxt    = ST_PEND;
                    w_conf_cnt_nxt = '0;
                end else begin
                    w_code_nxt  = w_dec.code;
                    w_valid_nxt = 1'b1;
                end
            end
            ST_PEND: begin
                // A fresh pattern restarts confirmation even if a tick lands in the same cycle.
                if (!w_bad) begin
                    w_state_nxt = ST_VALID;
                end else if (w_pat_chg) begin
                    w_conf_cnt_nxt = '0;
                end else if (w_tick) begin
                    if (r_conf_cnt >= CCW'(INVALID_CONFIRM_MS - 1)) begin
                        w_state_nxt    = ST_FAULT;
                        w_conf_cnt_nxt = '0;
                    end else begin
                        w_conf_cnt_nxt = r_conf_cnt + 1'b1;
                    end
                end
            end
            ST_FAULT: begin
                w_code_nxt  = LVL_INVALID;
                w_valid_nxt = 1'b0;
                w_perr_nxt  = 1'b1;
                if (w_dec.legal) w_state_nxt = ST_VALID;
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_INIT;
            r_init_cnt    <= '0;
            r_conf_cnt    <= '0;
            r_stable_prev <= '0;
            r_code        <= LVL_0;
            r_valid       <= 1'b0;
            r_perr        <= 1'b0;
            r_changed     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_init_cnt    <= w_init_cnt_nxt;
            r_conf_cnt    <= w_conf_cnt_nxt;
            r_stable_prev <= w_stable;
            r_code        <= w_code_nxt;
            r_valid       <= w_valid_nxt;
            r_perr        <= w_perr_nxt;
            r_changed     <= (w_code_nxt != r_code);
        end
    end

    assign level_code   = r_code;
    assign level_valid  = r_valid;
    assign code_changed = r_changed;
    assign pattern_err  = r_perr;

endmodule

// File: tb/tb_tank_level_encoder.sv
// Directed bench for tank_level_encoder at 1 MHz (1 ms = 1000 clocks).
module tb_tank_level_encoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] probe_in = 4'b0000;
    logic [2:0] level_code;
    logic       level_valid, code_changed, pattern_err, rate_err;

    int n_cmp = 0;
    int n_err = 0;
    int n_chg = 0;
    int n_perr = 0;

    tank_level_encoder #(
        .CLK_HZ             (1_000_000),
        .DEBOUNCE_MS        (2),
        .INVALID_CONFIRM_MS (3),
        .PROBE_ACTIVE_LOW   (1'b0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .probe_in     (probe_in),
        .level_code   (level_code),
        .level_valid  (level_valid),
        .code_changed (code_changed),
        .pattern_err  (pattern_err),
        .rate_err     (rate_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (code_changed) n_chg++;
        if (pattern_err)  n_perr++;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        probe_in = 4'b0011;
        cycles(5);
        @(negedge clk);
        n_cmp++; if (level_code !== 3'd0) begin n_err++; $display("FAIL rst_code: got %0d want 0", level_code); end
        n_cmp++; if (level_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", level_valid); end
        n_cmp++; if (code_changed !== 1'b0) begin n_err++; $display("FAIL rst_changed: got %b want 0", code_changed); end
        n_cmp++; if (pattern_err !== 1'b0) begin n_err++; $display("FAIL rst_perr: got %b want 0", pattern_err); end
        n_cmp++; if (rate_err !== 1'b0) begin n_err++; $display("FAIL rst_rate: got %b want 0", rate_err); end
    endtask

    task automatic test_init_to_valid();
        int c0;
        c0 = n_chg;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycles(1500);
        @(negedge clk);
        n_cmp++; if (level_code !== 3'd0) begin n_err++; $display("FAIL init_code: got %0d want 0", level_code); end
        n_cmp++; if (level_valid !== 1'b0) begin n_err++; $display("FAIL init_valid: got %b want 0", level_valid); end
        cycles(3500);
        @(negedge clk);
        n_cmp++; if (level_code !== 3'd2) begin n_err++; $display("FAIL t1_code: got %0d want 2", level_code); end
        n_cmp++; if (level_valid !== 1'b1) begin n_err++; $display("FAIL t1_valid: got %b want 1", level_valid); end
        n_cmp++; if (n_chg - c0 !== 1) begin n_err++; $display("FAIL t1_pulses: got %0d want 1", n_chg - c0); end
    endtask

    task automatic test_glitch();
        int c0;
        c0 = n_chg;
        probe_in = 4'b0111;
        cycles(1000);
        probe_in = 4'b0011;
        cycles(3000);
        @(negedge clk);
        n_cmp++; if (level_code !== 3'd2) begin n_err++; $display("FAIL glitch_code: got %0d want 2", level_code); end
        n_cmp++; if (n_chg - c0 !== 0) begin n_err++; $display("FAIL glitch_pulses: got %0d want 0", n_chg - c0); end
    endtask

    task automatic test_short_illegal();
        int c0, p0;
        c0 = n_chg;
        p0 = n_perr;
        probe_in = 4'b0101;
        cycles(2000);
        probe_in = 4'b0011;
        cycles(4000);
        @(negedge clk);
        n_cmp++; if (level_code !== 3'd2) begin n_err++; $display("FAIL short_code: got %0d want 2", level_code); end
        n_cmp++; if (level_valid !== 1'b1) begin n_err++; $display("FAIL short_valid: got %b want 1", level_valid); end
        n_cmp++; if (n_perr - p0 !== 0) begin n_err++; $display("FAIL short_perr_cycles: got %0d want 0", n_perr - p0); end
        n_cmp++; if (n_chg - c0 !== 0) begin n_err++; $display("FAIL short_pulses: got %0d want 0", n_chg - c0); end
    endtask

    task automatic test_fault_recover();
        int c0;
        c0 = n_chg;
        probe_in = 4'b0101;
        cycles(6000);
        @(negedge clk);
        n_cmp++; if (level_code !== 3'd7) begin n_err++; $display("FAIL fault_code: got %0d want 7", level_code); end
        n_cmp++; if (level_valid !== 1'b0) begin n_err++; $display("FAIL fault_valid: got %b want 0", level_valid); end
        n_cmp++; if (pattern_err !== 1'b1) begin n_err++; $display("FAIL fault_perr: got %b want 1", pattern_err); end
        probe_in = 4'b0111;
        cycles(3000);
        @(negedge clk);
        n_cmp++; if (level_code !== 3'd3) begin n_err++; $display("FAIL recov_code: got %0d want 3", level_code); end
        n_cmp++; if (level_valid !== 1'b1) begin n_err++; $display("FAIL recov_valid: got %b want 1", level_valid); end
        n_cmp++; if (pattern_err !== 1'b0) begin n_err++; $display("FAIL recov_perr: got %b want 0", pattern_err); end
        n_cmp++; if (n_chg - c0 !== 2) begin n_err++; $display("FAIL fault_pulses: got %0d want 2", n_chg - c0); end
    endtask

    task automatic test_reset_in_fault();
        probe_in = 4'b0101;
        cycles(6000);
        @(negedge clk);
        n_cmp++; if (pattern_err !== 1'b1) begin n_err++; $display("FAIL pre_rst_perr: got %b want 1", pattern_err); end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({level_code, level_valid, code_changed, pattern_err, rate_err} !== 7'd0)
            begin n_err++; $display("FAIL async_rst_outs: got %b want 0000000", {level_code, level_valid, code_changed, pattern_err, rate_err}); end
        probe_in = 4'b0001;
        cycles(3);
        rst_n = 1'b1;
        cycles(1500);
        @(negedge clk);
        n_cmp++; if ({level_code, level_valid} !== 4'b0000) begin n_err++; $display("FAIL reinit_code_valid: got %b want 0000", {level_code, level_valid}); end
        cycles(3500);
        @(negedge clk);
        n_cmp++; if (level_code !== 3'd1) begin n_err++; $display("FAIL reinit_code: got %0d want 1", level_code); end
        n_cmp++; if (level_valid !== 1'b1) begin n_err++; $display("FAIL reinit_valid: got %b want 1", level_valid); end
    endtask

    task automatic test_level_jump();
        probe_in = 4'b0111;
        cycles(2500);
        @(negedge clk);
`ifdef LVL_ENC_RATE_CHECK_EN
        n_cmp++; if (level_code !== 3'd1) begin n_err++; $display("FAIL jump_code: got %0d want 1", level_code); end
        n_cmp++; if (rate_err !== 1'b1) begin n_err++; $display("FAIL jump_rate: got %b want 1", rate_err); end
`else
        n_cmp++; if (level_code !== 3'd3) begin n_err++; $display("FAIL jump_code: got %0d want 3", level_code); end
        n_cmp++; if (rate_err !== 1'b0) begin n_err++; $display("FAIL jump_rate: got %b want 0", rate_err); end
`endif
        n_cmp++; if (pattern_err !== 1'b0) begin n_err++; $display("FAIL jump_perr: got %b want 0", pattern_err); end
    endtask

    initial begin
        test_reset();
        test_init_to_valid();
        test_glitch();
        test_short_illegal();
        test_fault_recover();
        test_reset_in_fault();
        test_level_jump();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
